// File: rtl/led_shift_sched.sv
// led_shift_sched: divides the clock into shift ticks for a one-hot LED shifter
// and issues one-cycle shift (o_valid) / reseed (o_load) requests.
`default_nettype none

module led_shift_sched #(
  parameter int NB_LEDS    = 4,
  parameter int NB_POS     = 2,
  parameter int NB_COUNTER = 32,
  parameter int R0         = 100_000_000,
  parameter int R1         = 50_000_000,
  parameter int R2         = 25_000_000,
  parameter int R3         = 12_500_000
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [3:0]        i_sw,
  input  logic              i_btn_step,
  output logic              o_valid,
  output logic              o_load,
  output logic              o_dir,
  output logic [NB_POS-1:0] o_pos,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [NB_COUNTER-1:0] LIM0     = NB_COUNTER'(R0);
  localparam logic [NB_COUNTER-1:0] LIM1     = NB_COUNTER'(R1);
  localparam logic [NB_COUNTER-1:0] LIM2     = NB_COUNTER'(R2);
  localparam logic [NB_COUNTER-1:0] LIM3     = NB_COUNTER'(R3);
  localparam logic [NB_POS-1:0]     LAST_POS = NB_POS'(NB_LEDS - 1);

  state_t                state;
  logic [3:0]            sw_meta, sw_sync;
  logic                  btn_meta, btn_sync, btn_prev;
  logic [1:0]            spd_prev;
  logic [NB_COUNTER-1:0] cnt;

  logic                  en, dir, step;
  logic [1:0]            spd;
  logic [NB_COUNTER-1:0] limit_m1;
  logic                  at_term, spd_changed, tick;

  assign en   = sw_sync[0];
  assign spd  = sw_sync[2:1];
  assign dir  = sw_sync[3];
  assign step = btn_sync & ~btn_prev;

  always_comb begin
    limit_m1 = LIM0 - NB_COUNTER'(1);
    case (spd)
      2'b00: limit_m1 = LIM0 - NB_COUNTER'(1);
      2'b01: limit_m1 = LIM1 - NB_COUNTER'(1);
      2'b10: limit_m1 = LIM2 - NB_COUNTER'(1);
      2'b11: limit_m1 = LIM3 - NB_COUNTER'(1);
      default: limit_m1 = LIM0 - NB_COUNTER'(1);
    endcase
  end

  // A speed change that leaves cnt at or past the new terminal restarts the period silently.
  assign at_term     = (cnt >= limit_m1);
  assign spd_changed = (spd != spd_prev);
  assign tick        = ((state == RUN) && en && at_term && !spd_changed) ||
                       ((state == HOLD) && step);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state    <= IDLE;
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
      spd_prev <= '0;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_load   <= 1'b0;
      o_dir    <= 1'b0;
      o_pos    <= '0;
    end else begin
      sw_meta  <= i_sw;
      sw_sync  <= sw_meta;
      btn_meta <= i_btn_step;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      spd_prev <= spd;
      o_valid  <= 1'b0;
      o_load   <= 1'b0;

      case (state)
        IDLE: begin
          state  <= LOAD;
          o_load <= 1'b1;
          o_dir  <= dir;
          o_pos  <= '0;
          cnt    <= '0;
        end
        LOAD: begin
          cnt   <= '0;
          state <= en ? RUN : HOLD;
        end
        RUN: begin
          if (!en) begin
            state <= HOLD;
            if (at_term) cnt <= '0;
          end else if (at_term) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + NB_COUNTER'(1);
          end
        end
        HOLD: begin
          if (en) state <= RUN;
        end
        default: state <= IDLE;
      endcase

      // Wrapping the pattern reseeds the shifter and is the only point where dir is taken.
      if (tick) begin
        if (o_pos == LAST_POS) begin
          o_load <= 1'b1;
          o_pos  <= '0;
          o_dir  <= dir;
        end else begin
          o_valid <= 1'b1;
          o_pos   <= o_pos + NB_POS'(1);
        end
      end
    end
  end

  assign o_state = state;

endmodule

`default_nettype wire

// File: tb/tb_led_shift_sched.sv
// Directed bench for led_shift_sched with short tick periods (4/8/16/32 clocks).
`default_nettype none

module tb_led_shift_sched;

  logic       clock = 1'b0;
  logic       i_reset;
  logic [3:0] i_sw;
  logic       i_btn_step;
  logic       o_valid, o_load, o_dir;
  logic [1:0] o_pos, o_state;

  int vectors = 0;
  int miscompares = 0;

  led_shift_sched #(
    .NB_LEDS(4), .NB_POS(2), .NB_COUNTER(32),
    .R0(4), .R1(8), .R2(16), .R3(32)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_sw       (i_sw),
    .i_btn_step (i_btn_step),
    .o_valid    (o_valid),
    .o_load     (o_load),
    .o_dir      (o_dir),
    .o_pos      (o_pos),
    .o_state    (o_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic       v, l, d;
    logic [1:0] p, s;
  } vec_t;

  vec_t tbl[30];

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_evt(output int n);
    n = 0;
    do begin
      clk_step();
      n++;
    end while (!(o_valid || o_load) && n < 200);
    chk("event_seen", int'(o_valid || o_load), 1);
  endtask

  task automatic run_count(input int cycles, inout int nv, inout int nl);
    for (int k = 0; k < cycles; k++) begin
      clk_step();
      nv += int'(o_valid);
      nl += int'(o_load);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] sw, input logic v,
                              input logic l, input logic [1:0] p, input logic [1:0] s);
    vec_t r;
    r.rst = rst; r.sw = sw; r.btn = 1'b0;
    r.v = v; r.l = l; r.d = 1'b0; r.p = p; r.s = s;
    return r;
  endfunction

  initial begin
    int n, nv, nl;

    // Reset, LOAD -> HOLD (en still in synchronizer) -> RUN, then ticks every 4 clocks.
    tbl[0]  = mk(1, 4'b0001, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4'b0001, 0, 0, 0, 0);
    tbl[2]  = mk(0, 4'b0001, 0, 1, 0, 1);
    tbl[3]  = mk(0, 4'b0001, 0, 0, 0, 3);
    tbl[4]  = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[5]  = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[6]  = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[7]  = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[8]  = mk(0, 4'b0001, 1, 0, 1, 2);
    tbl[9]  = mk(0, 4'b0001, 0, 0, 1, 2);
    tbl[10] = mk(0, 4'b0001, 0, 0, 1, 2);
    tbl[11] = mk(0, 4'b0001, 0, 0, 1, 2);
    tbl[12] = mk(0, 4'b0001, 1, 0, 2, 2);
    tbl[13] = mk(0, 4'b0001, 0, 0, 2, 2);
    tbl[14] = mk(0, 4'b0001, 0, 0, 2, 2);
    tbl[15] = mk(0, 4'b0001, 0, 0, 2, 2);
    tbl[16] = mk(0, 4'b0001, 1, 0, 3, 2);
    tbl[17] = mk(0, 4'b0001, 0, 0, 3, 2);
    tbl[18] = mk(0, 4'b0001, 0, 0, 3, 2);
    tbl[19] = mk(0, 4'b0001, 0, 0, 3, 2);
    tbl[20] = mk(0, 4'b0001, 0, 1, 0, 2);
    tbl[21] = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[22] = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[23] = mk(0, 4'b0001, 0, 0, 0, 2);
    tbl[24] = mk(0, 4'b0001, 1, 0, 1, 2);
    // en drops so that its synchronized value falls on the terminal-count cycle.
    tbl[25] = mk(0, 4'b0001, 0, 0, 1, 2);
    tbl[26] = mk(0, 4'b0000, 0, 0, 1, 2);
    tbl[27] = mk(0, 4'b0000, 0, 0, 1, 2);
    tbl[28] = mk(0, 4'b0000, 0, 0, 1, 3);
    tbl[29] = mk(0, 4'b0000, 0, 0, 1, 3);

    i_reset = 1'b1; i_sw = 4'b0001; i_btn_step = 1'b0;
    for (int i = 0; i < 30; i++) begin
      i_reset = tbl[i].rst; i_sw = tbl[i].sw; i_btn_step = tbl[i].btn;
      clk_step();
      chk($sformatf("row%0d{v,l,d,pos,state}", i),
          int'({o_valid, o_load, o_dir, o_pos, o_state}),
          int'({tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].p, tbl[i].s}));
      if (i == 28) chk("cnt_after_en_drop", int'(dut.cnt), 0);
    end

    // Three step presses in HOLD from pos 1: valid, valid, load.
    nv = 0; nl = 0;
    for (int k = 0; k < 3; k++) begin
      i_btn_step = 1'b1; run_count(2, nv, nl);
      i_btn_step = 1'b0; run_count(2, nv, nl);
    end
    run_count(4, nv, nl);
    chk("step3_valids", nv, 2);
    chk("step3_loads", nl, 1);
    chk("step3_pos", int'(o_pos), 0);
    chk("step3_state", int'(o_state), 3);

    // A held button is a single tick.
    nv = 0; nl = 0;
    i_btn_step = 1'b1; run_count(10, nv, nl);
    i_btn_step = 1'b0; run_count(4, nv, nl);
    chk("held_ticks", nv + nl, 1);
    chk("held_pos", int'(o_pos), 1);

    // Direction is taken only at the next load.
    i_sw = 4'b1001;
    wait_evt(n);
    chk("dir_v1_valid", int'(o_valid), 1);
    chk("dir_v1_pos", int'(o_pos), 2);
    chk("dir_v1_dir", int'(o_dir), 0);
    wait_evt(n);
    chk("dir_v2_pos", int'(o_pos), 3);
    chk("dir_v2_dir", int'(o_dir), 0);
    wait_evt(n);
    chk("dir_load", int'(o_load), 1);
    chk("dir_load_pos", int'(o_pos), 0);
    chk("dir_load_dir", int'(o_dir), 1);
    chk("period_r0", n, 4);

    // Mid-run reset at pos 2.
    wait_evt(n);
    wait_evt(n);
    chk("pre_reset_pos", int'(o_pos), 2);
    i_reset = 1'b1;
    clk_step();
    chk("reset_outputs", int'({o_valid, o_load, o_dir, o_pos, o_state}), 0);
    i_reset = 1'b0;
    clk_step();
    chk("reload_load", int'(o_load), 1);
    chk("reload_pos", int'(o_pos), 0);
    chk("reload_state", int'(o_state), 1);

    // Speed change R2 -> R0 with cnt at 10: no tick, cnt cleared, next tick 4 clocks on.
    i_sw = 4'b0101;
    wait_evt(n);
    wait_evt(n);
    wait_evt(n);
    chk("period_r2", n, 16);
    nv = 0; nl = 0;
    run_count(8, nv, nl);
    i_sw = 4'b0001;
    run_count(3, nv, nl);
    chk("spd_change_no_tick", nv + nl, 0);
    chk("spd_change_cnt", int'(dut.cnt), 0);
    wait_evt(n);
    chk("spd_change_next", n, 4);
    wait_evt(n);
    chk("period_r0_again", n, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
